// File: rtl/alu_arbiter_if.sv
// Requester request/response channels plus the registered bus toward the shared ALU.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
);
   logic             req0_valid;
   logic             req0_ready;
   logic [OPW-1:0]   req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_data;
   logic             rsp0_zero;

   logic             req1_valid;
   logic             req1_ready;
   logic [OPW-1:0]   req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_data;
   logic             rsp1_zero;

   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_in0;
   logic [WIDTH-1:0] alu_in1;
   logic [WIDTH-1:0] alu_out;
   logic             alu_is_zero;
   logic             busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      input  alu_out, alu_is_zero,
      output req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
      output req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
      output alu_op, alu_in0, alu_in1, busy
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      output alu_out, alu_is_zero,
      input  req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
      input  req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
      input  alu_op, alu_in0, alu_in1, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Optional perf counters (grant0_cnt, grant1_cnt, stall_cnt) enabled by ALU_ARB_PERF_EN.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
`ifdef ALU_ARB_PERF_EN
   ,parameter int CNTW = 16
`endif
) (
   input  logic            clk,
   input  logic            reset_n,
   alu_arbiter_if.slave    bus
`ifdef ALU_ARB_PERF_EN
   ,output logic [CNTW-1:0] grant0_cnt
   ,output logic [CNTW-1:0] grant1_cnt
   ,output logic [CNTW-1:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [OPW-1:0] OP_RSVD = '1;

   state_t           state_q;
   state_t           state_d;
   logic             owner_q;
   logic             last_grant_q;
   logic [OPW-1:0]   op_q;
   logic [WIDTH-1:0] in0_q;
   logic [WIDTH-1:0] in1_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_zero_q;

   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             rsp_ready_sel;

   // A tie goes to whichever requester did not win last; reset_n gates ready low during reset.
   always_comb begin
      grant0        = bus.req0_valid & (~bus.req1_valid | last_grant_q);
      grant1        = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
      accept        = (state_q == IDLE) & reset_n & (grant0 | grant1);
      rsp_ready_sel = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready_sel) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = (state_q == IDLE) & reset_n & grant0;
      bus.req1_ready = (state_q == IDLE) & reset_n & grant1;
      bus.rsp0_valid = (state_q == RESP) & ~owner_q;
      bus.rsp1_valid = (state_q == RESP) & owner_q;
      bus.busy       = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q         <= '0;
         in0_q        <= '0;
         in1_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q         <= grant1 ? bus.req1_op : bus.req0_op;
            in0_q        <= grant1 ? bus.req1_a  : bus.req0_a;
            in1_q        <= grant1 ? bus.req1_b  : bus.req0_b;
            owner_q      <= grant1;
            last_grant_q <= grant1;
         end
         // The reserved opcode never trusts the ALU: result is forced to zero.
         if (state_q == EXEC) begin
            if (op_q == OP_RSVD) begin
               rsp_data_q <= '0;
               rsp_zero_q <= 1'b1;
            end else begin
               rsp_data_q <= bus.alu_out;
               rsp_zero_q <= bus.alu_is_zero;
            end
         end
      end
   end

   assign bus.alu_op    = op_q;
   assign bus.alu_in0   = in0_q;
   assign bus.alu_in1   = in1_q;
   assign bus.rsp0_data = rsp_data_q;
   assign bus.rsp0_zero = rsp_zero_q;
   assign bus.rsp1_data = rsp_data_q;
   assign bus.rsp1_zero = rsp_zero_q;

`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant0_cnt <= '0;
         grant1_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (accept && !grant1 && grant0_cnt != '1) grant0_cnt <= grant0_cnt + 1'b1;
         if (accept && grant1 && grant1_cnt != '1)  grant1_cnt <= grant1_cnt + 1'b1;
         if (state_q == RESP && !rsp_ready_sel && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared-ALU side.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   alu_arbiter_if #(.WIDTH(32), .OPW(3)) bus ();

`ifdef ALU_ARB_PERF_EN
   logic [15:0] grant0_cnt, grant1_cnt, stall_cnt;
`endif

   alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
`ifdef ALU_ARB_PERF_EN
      ,.grant0_cnt (grant0_cnt)
      ,.grant1_cnt (grant1_cnt)
      ,.stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a << b;
         3'd3:    return a >> b;
         3'd4:    return a;
         3'd5:    return a & b;
         3'd6:    return a | b;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   assign bus.alu_out     = alu_f(bus.alu_op, bus.alu_in0, bus.alu_in1);
   assign bus.alu_is_zero = (bus.alu_out == 32'd0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input int n, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   function automatic logic req_r(input int n);
      return (n == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction
   function automatic logic rsp_v(input int n);
      return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
   endfunction
   function automatic logic [31:0] rsp_d(input int n);
      return (n == 0) ? bus.rsp0_data : bus.rsp1_data;
   endfunction
   function automatic logic rsp_z(input int n);
      return (n == 0) ? bus.rsp0_zero : bus.rsp1_zero;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single uncontended op: immediate ready, response exactly two edges after accept.
   task automatic run_single(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_d, input logic exp_z, input string tag);
      int cyc = 0;
      drive_req(n, 1'b1, op, a, b);
      #1;
      while (!req_r(n) && cyc < 8) begin
         tick();
         cyc++;
      end
      check({tag, "_ready_wait"}, cyc, 0);
      tick();
      drive_req(n, 1'b0, 3'd0, 32'd0, 32'd0);
      check({tag, "_exec_valid"}, rsp_v(n), 1'b0);
      check({tag, "_exec_busy"}, bus.busy, 1'b1);
      tick();
      check({tag, "_rsp_valid"}, rsp_v(n), 1'b1);
      check({tag, "_rsp_other"}, rsp_v(1 - n), 1'b0);
      check({tag, "_rsp_data"}, rsp_d(n), exp_d);
      check({tag, "_rsp_zero"}, rsp_z(n), exp_z);
      tick();
      check({tag, "_done_valid"}, rsp_v(n), 1'b0);
      check({tag, "_done_busy"}, bus.busy, 1'b0);
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   logic [2:0]  f_op0 [3] = '{3'd0, 3'd1, 3'd5};
   logic [31:0] f_a0  [3] = '{32'd10, 32'd100, 32'hF0};
   logic [31:0] f_b0  [3] = '{32'd20, 32'd1, 32'h3C};
   logic [31:0] f_e0  [3] = '{32'd30, 32'd99, 32'h30};
   logic [2:0]  f_op1 [3] = '{3'd3, 3'd4, 3'd6};
   logic [31:0] f_a1  [3] = '{32'h80, 32'h55, 32'h100};
   logic [31:0] f_b1  [3] = '{32'd3, 32'd9, 32'h1};
   logic [31:0] f_e1  [3] = '{32'h10, 32'h55, 32'h101};

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx0, idx1, ridx0, ridx1, k, cyc;
      drive_req(0, 1'b1, 3'd0, 32'd0, 32'd0);
      drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_req0_ready", bus.req0_ready, 1'b0);
      check("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      check("rst_rsp_data", bus.rsp0_data, 32'd0);
      check("rst_alu_in0", bus.alu_in0, 32'd0);
      check("rst_alu_op", bus.alu_op, 32'd0);
      bus.req0_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      run_single(0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, "add");

      // Contention from a fresh reset: req0 wins first.
      reset_pulse();
      drive_req(0, 1'b1, 3'd1, 32'd9, 32'd9);
      drive_req(1, 1'b1, 3'd6, 32'd3, 32'd4);
      #1;
      check("tie_req0_ready", bus.req0_ready, 1'b1);
      check("tie_req1_ready", bus.req1_ready, 1'b0);
      tick();
      drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      check("tie_exec_req1_ready", bus.req1_ready, 1'b0);
      tick();
      check("tie_rsp0_valid", bus.rsp0_valid, 1'b1);
      check("tie_rsp0_data", bus.rsp0_data, 32'd0);
      check("tie_rsp0_zero", bus.rsp0_zero, 1'b1);
      check("tie_rsp1_idle", bus.rsp1_valid, 1'b0);
      tick();
      check("tie_req1_ready2", bus.req1_ready, 1'b1);
      tick();
      drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
      tick();
      check("tie_rsp1_valid", bus.rsp1_valid, 1'b1);
      check("tie_rsp1_data", bus.rsp1_data, 32'd7);
      check("tie_rsp1_zero", bus.rsp1_zero, 1'b0);
      tick();

      // Continuous contention: grants alternate starting with req0.
      idx0 = 0; idx1 = 0; ridx0 = 0; ridx1 = 0; k = 0; cyc = 0;
      while ((ridx0 < 3 || ridx1 < 3) && cyc < 40) begin
         if (idx0 < 3) drive_req(0, 1'b1, f_op0[idx0], f_a0[idx0], f_b0[idx0]);
         else          drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
         if (idx1 < 3) drive_req(1, 1'b1, f_op1[idx1], f_a1[idx1], f_b1[idx1]);
         else          drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
         #1;
         if (bus.rsp0_valid) begin
            check("fair_rsp0_data", bus.rsp0_data, f_e0[ridx0]);
            ridx0++;
         end
         if (bus.rsp1_valid) begin
            check("fair_rsp1_data", bus.rsp1_data, f_e1[ridx1]);
            ridx1++;
         end
         if (bus.req0_ready && bus.req1_ready) check("fair_both_ready", 32'd1, 32'd0);
         if (bus.req0_ready || bus.req1_ready) begin
            check("fair_grant", {31'd0, bus.req1_ready}, k % 2);
            k++;
            if (bus.req1_ready) idx1++;
            else                idx0++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check("fair_grants", k, 6);
      check("fair_rsp0_count", ridx0, 3);
      check("fair_rsp1_count", ridx1, 3);
      drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
      tick();

      // Response stall on req1 with req0 waiting.
      bus.rsp1_ready = 1'b0;
      drive_req(1, 1'b1, 3'd0, 32'h11, 32'h22);
      #1;
      check("stall_req1_ready", bus.req1_ready, 1'b1);
      tick();
      drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
      drive_req(0, 1'b1, 3'd0, 32'd1, 32'd2);
      #1;
      check("stall_exec_req0_ready", bus.req0_ready, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("stall_valid", bus.rsp1_valid, 1'b1);
         check("stall_data", bus.rsp1_data, 32'h33);
         check("stall_busy", bus.busy, 1'b1);
         check("stall_req0_ready", bus.req0_ready, 1'b0);
         tick();
      end
      bus.rsp1_ready = 1'b1;
      #1;
      check("stall_release_valid", bus.rsp1_valid, 1'b1);
      tick();
      check("stall_after_valid", bus.rsp1_valid, 1'b0);
      check("stall_req0_ready_idle", bus.req0_ready, 1'b1);
`ifdef ALU_ARB_PERF_EN
      check("perf_stall_cnt", stall_cnt, 32'd4);
`endif
      tick();
      drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
      tick();
      check("stall_rsp0_data", bus.rsp0_data, 32'd3);
      tick();

      run_single(1, 3'd7, 32'd1, 32'd1, 32'd0, 1'b1, "rsvd");
      run_single(0, 3'd2, 32'd1, 32'd31, 32'h80000000, 1'b0, "shl");
      run_single(1, 3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, "wrap");

      // Reset during EXEC abandons the op.
      drive_req(0, 1'b1, 3'd0, 32'd2, 32'd3);
      tick();
      drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive_req(1, 1'b1, 3'd0, 32'd4, 32'd4);
      reset_n = 1'b0;
      #1;
      check("mrst_busy", bus.busy, 1'b0);
      check("mrst_rsp0_valid", bus.rsp0_valid, 1'b0);
      check("mrst_alu_in0", bus.alu_in0, 32'd0);
      check("mrst_req1_ready", bus.req1_ready, 1'b0);
      tick();
      check("mrst_no_rsp", bus.rsp0_valid, 1'b0);
      drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      run_single(1, 3'd1, 32'd10, 32'd3, 32'd7, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
